// File: rtl/buffer_if_id.sv
`default_nettype none
// ============================================================================
// Module      : buffer_if_id
// Description : IF/ID pipeline register. Captures the fetched instruction
//               word on every rising clock edge and holds it stable for the
//               decode stage for the whole cycle. Pure storage: there is no
//               decode, stall or flush logic.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_if_id #(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0000
) (
    output logic [WIDTH-1:0] out_instr,
    input  logic [WIDTH-1:0] in_instr,
    input  logic             clk,
    input  logic             rst
);

    // Held instruction word; RESET_VALUE is seen by ID as a bubble.
    logic [WIDTH-1:0] r_instr;

    // Capture every cycle (no enable); reset is asynchronous and active-low so
    // a bubble is injected immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= RESET_VALUE;
        end else begin
            r_instr <= in_instr;
        end
    end

    // Output comes straight from the register: no combinational path from
    // in_instr, so the decode stage sees a value that changes only at edges.
    assign out_instr = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_buffer_if_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_if_id
// Description : Directed self-checking bench for the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_if_id;

    localparam int c_width = 16;

    logic [c_width-1:0] out_instr;
    logic [c_width-1:0] in_instr;
    logic               clk;
    logic               rst;

    int n_checks;
    int n_fail;

    buffer_if_id #(
        .WIDTH      (c_width),
        .RESET_VALUE(16'h0000)
    ) dut (
        .out_instr(out_instr),
        .in_instr (in_instr),
        .clk      (clk),
        .rst      (rst)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run can never hang.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1);
    end

    // Reset held from t=0 with a non-zero input: output must stay at 0000.
    task automatic test_reset();
        #1;
        n_checks++;
        if (out_instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_t0: actual=%h required=%h", out_instr, 16'h0000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_instr !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_edge%0d: actual=%h required=%h", i, out_instr, 16'h0000);
            end
        end
    endtask

    // Release reset, then a mid-cycle change is taken only at the next edge.
    task automatic test_basic_capture();
        @(negedge clk);
        in_instr = 16'h0001;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_instr !== 16'h0001) begin
            n_fail++;
            $display("FAIL release_first_capture: actual=%h required=%h", out_instr, 16'h0001);
        end
        @(negedge clk);
        in_instr = 16'hF230;
        #2;
        n_checks++;
        if (out_instr !== 16'h0001) begin
            n_fail++;
            $display("FAIL capture_before_edge: actual=%h required=%h", out_instr, 16'h0001);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_instr !== 16'hF230) begin
            n_fail++;
            $display("FAIL capture_after_edge: actual=%h required=%h", out_instr, 16'hF230);
        end
    endtask

    // Successive values, each one edge late; previous value held mid-cycle.
    task automatic test_stream();
        logic [15:0] vals [4];
        logic [15:0] prev;
        vals[0] = 16'hF400;
        vals[1] = 16'hF500;
        vals[2] = 16'hF600;
        vals[3] = 16'hF700;
        prev    = 16'hF230;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_instr = vals[i];
            #1;
            n_checks++;
            if (out_instr !== prev) begin
                n_fail++;
                $display("FAIL stream_hold%0d: actual=%h required=%h", i, out_instr, prev);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_instr !== vals[i]) begin
                n_fail++;
                $display("FAIL stream%0d: actual=%h required=%h", i, out_instr, vals[i]);
            end
            prev = vals[i];
        end
    endtask

    // Two input changes between edges: only the last one is captured.
    task automatic test_glitch();
        @(negedge clk);
        in_instr = 16'hF400;
        #2;
        n_checks++;
        if (out_instr !== 16'hF700) begin
            n_fail++;
            $display("FAIL glitch_first_change: actual=%h required=%h", out_instr, 16'hF700);
        end
        in_instr = 16'h1234;
        #1;
        n_checks++;
        if (out_instr !== 16'hF700) begin
            n_fail++;
            $display("FAIL glitch_second_change: actual=%h required=%h", out_instr, 16'hF700);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_instr !== 16'h1234) begin
            n_fail++;
            $display("FAIL glitch_capture: actual=%h required=%h", out_instr, 16'h1234);
        end
    endtask

    // Reset asserted between edges clears at once; capture resumes after release.
    task automatic test_async_reset();
        @(negedge clk);
        in_instr = 16'hF600;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_instr !== 16'hF600) begin
            n_fail++;
            $display("FAIL areset_preload: actual=%h required=%h", out_instr, 16'hF600);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL areset_immediate: actual=%h required=%h", out_instr, 16'h0000);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL areset_held_edge: actual=%h required=%h", out_instr, 16'h0000);
        end
        @(negedge clk);
        in_instr = 16'hF700;
        rst      = 1'b1;
        #1;
        n_checks++;
        if (out_instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL areset_release_no_edge: actual=%h required=%h", out_instr, 16'h0000);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_instr !== 16'hF700) begin
            n_fail++;
            $display("FAIL areset_resume: actual=%h required=%h", out_instr, 16'hF700);
        end
    endtask

    // Held input keeps the output constant across several edges.
    task automatic test_hold();
        @(negedge clk);
        in_instr = 16'hF500;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_instr !== 16'hF500) begin
                n_fail++;
                $display("FAIL hold_edge%0d: actual=%h required=%h", i, out_instr, 16'hF500);
            end
            @(negedge clk);
            n_checks++;
            if (out_instr !== 16'hF500) begin
                n_fail++;
                $display("FAIL hold_mid%0d: actual=%h required=%h", i, out_instr, 16'hF500);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        in_instr = 16'hF230;
        test_reset();
        test_basic_capture();
        test_stream();
        test_glitch();
        test_async_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
